// File: rtl/prd_gen_pkg.sv
// prd_gen_pkg: shared widths, FSM state type and configuration sanitiser
// for the programmable pulse-train generator.
package prd_gen_pkg;

  localparam int W_DEF       = 32;
  localparam int NW_DEF      = 16;
  localparam int MIN_PRD_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [W_DEF-1:0] prd;
    logic [W_DEF-1:0] hi;
  } cfg_t;

  // Clamp a requested period/high-time pair so that every period has at
  // least one high and one low cycle.
  function automatic cfg_t cfg_fix(input logic [W_DEF-1:0] prd,
                                   input logic [W_DEF-1:0] hi,
                                   input logic [W_DEF-1:0] min_prd);
    cfg_t r;
    r.prd = (prd < min_prd) ? min_prd : prd;
    r.hi  = (hi == {W_DEF{1'b0}}) ? {{(W_DEF-1){1'b0}}, 1'b1} : hi;
    r.hi  = (r.hi >= r.prd) ? (r.prd - {{(W_DEF-1){1'b0}}, 1'b1}) : r.hi;
    return r;
  endfunction

endpackage

// File: rtl/prd_gen_cfg.sv
// prd_cfg: captures sanitised configuration, holds it pending while a
// waveform is running, applies it at a period start and pulses upd_ack.
module prd_cfg
  import prd_gen_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NW      = NW_DEF,
  parameter int MIN_PRD = MIN_PRD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          idle,
  input  logic          start,
  input  logic [W-1:0]  prd,
  input  logic [W-1:0]  hi,
  input  logic [NW-1:0] nper,
  input  logic          upd,
  output logic [W-1:0]  prd_a,
  output logic [W-1:0]  hi_a,
  output logic [NW-1:0] nper_a,
  output logic [W-1:0]  hi_n,
  output logic          apply,
  output logic          upd_ack
);

  cfg_t          fix_s;
  logic [W-1:0]  fix_prd_s;
  logic [W-1:0]  fix_hi_s;
  logic [W-1:0]  prd_a_r;
  logic [W-1:0]  hi_a_r;
  logic [NW-1:0] nper_a_r;
  logic [W-1:0]  prd_p_r;
  logic [W-1:0]  hi_p_r;
  logic [NW-1:0] nper_p_r;
  logic          pend_r;
  logic          ack_r;
  logic [W-1:0]  hi_n_s;
  logic          apply_s;

  assign fix_s     = cfg_fix(W_DEF'(prd), W_DEF'(hi), W_DEF'(MIN_PRD));
  assign fix_prd_s = W'(fix_s.prd);
  assign fix_hi_s  = W'(fix_s.hi);

  // High time of a period starting this cycle, and whether a new config takes effect
  always_comb begin
    hi_n_s  = hi_a_r;
    apply_s = 1'b0;
    if (idle && upd) begin
      hi_n_s = fix_hi_s;
    end else if (pend_r) begin
      hi_n_s = hi_p_r;
    end else begin
      hi_n_s = hi_a_r;
    end
    apply_s = start && ((idle && upd) || pend_r);
  end

  // Active/pending configuration registers and acknowledge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prd_a_r  <= W'(MIN_PRD);
      hi_a_r   <= {{(W-1){1'b0}}, 1'b1};
      nper_a_r <= {NW{1'b0}};
      prd_p_r  <= {W{1'b0}};
      hi_p_r   <= {W{1'b0}};
      nper_p_r <= {NW{1'b0}};
      pend_r   <= 1'b0;
      ack_r    <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      if (idle) begin
        if (upd) begin
          prd_a_r  <= fix_prd_s;
          hi_a_r   <= fix_hi_s;
          nper_a_r <= nper;
          pend_r   <= 1'b0;
          ack_r    <= 1'b1;
        end else if (start && pend_r) begin
          prd_a_r  <= prd_p_r;
          hi_a_r   <= hi_p_r;
          nper_a_r <= nper_p_r;
          pend_r   <= 1'b0;
          ack_r    <= 1'b1;
        end
      end else begin
        if (start && pend_r) begin
          prd_a_r  <= prd_p_r;
          hi_a_r   <= hi_p_r;
          nper_a_r <= nper_p_r;
          pend_r   <= 1'b0;
          ack_r    <= 1'b1;
        end
        // a newer request always supersedes whatever was pending
        if (upd) begin
          prd_p_r  <= fix_prd_s;
          hi_p_r   <= fix_hi_s;
          nper_p_r <= nper;
          pend_r   <= 1'b1;
        end
      end
    end
  end

  assign prd_a   = prd_a_r;
  assign hi_a    = hi_a_r;
  assign nper_a  = nper_a_r;
  assign hi_n    = hi_n_s;
  assign apply   = apply_s;
  assign upd_ack = ack_r;

endmodule

// File: rtl/prd_gen.sv
// prd_gen: programmable pulse-train generator. FSM, phase down-counter and
// burst counter live here; configuration handling is in prd_cfg.
module prd_gen
  import prd_gen_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NW      = NW_DEF,
  parameter int MIN_PRD = MIN_PRD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  prd,
  input  logic [W-1:0]  hi,
  input  logic [NW-1:0] nper,
  input  logic          upd,
  output logic          upd_ack,
  output logic          sig,
  output logic          medge,
  output logic          act,
  output logic          done
);

  state_t        state_r, state_nx_s;
  logic [W-1:0]  cnt_r, cnt_nx_s;
  logic [NW-1:0] bcnt_r, bcnt_nx_s, bsum_s;
  logic          blk_r;
  logic          start_s, done_nx_s, idle_s, apply_s;
  logic [W-1:0]  prd_a_s, hi_a_s, hi_n_s;
  logic [NW-1:0] nper_a_s;
  logic          sig_nx_s, medge_nx_s, act_nx_s;
  logic          sig_r, medge_r, act_r, done_r;

  assign idle_s = (state_r == IDLE);
  assign bsum_s = bcnt_r + NW'(1);

  prd_cfg #(.W(W), .NW(NW), .MIN_PRD(MIN_PRD)) u_cfg (
    .clk     (clk),
    .rst     (rst),
    .idle    (idle_s),
    .start   (start_s),
    .prd     (prd),
    .hi      (hi),
    .nper    (nper),
    .upd     (upd),
    .prd_a   (prd_a_s),
    .hi_a    (hi_a_s),
    .nper_a  (nper_a_s),
    .hi_n    (hi_n_s),
    .apply   (apply_s),
    .upd_ack (upd_ack)
  );

  // State, phase counter, burst counter and post-burst restart lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {W{1'b0}};
      bcnt_r  <= {NW{1'b0}};
      blk_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      bcnt_r  <= bcnt_nx_s;
      // after a burst, en must be seen low before another start
      blk_r   <= done_nx_s ? 1'b1 : (en ? blk_r : 1'b0);
    end
  end

  // Next state, counter reloads and period-boundary decisions
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    bcnt_nx_s  = bcnt_r;
    start_s    = 1'b0;
    done_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && !blk_r) begin
          state_nx_s = HIGH;
          cnt_nx_s   = hi_n_s - W'(1);
          start_s    = 1'b1;
          bcnt_nx_s  = {NW{1'b0}};
        end else begin
          bcnt_nx_s  = {NW{1'b0}};
        end
      end
      HIGH: begin
        if (cnt_r == {W{1'b0}}) begin
          state_nx_s = LOW;
          cnt_nx_s   = prd_a_s - hi_a_s - W'(1);
        end else begin
          cnt_nx_s   = cnt_r - W'(1);
        end
      end
      LOW: begin
        if (cnt_r != {W{1'b0}}) begin
          cnt_nx_s = cnt_r - W'(1);
        end else if ((nper_a_s != {NW{1'b0}}) && (bsum_s == nper_a_s)) begin
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
          bcnt_nx_s  = {NW{1'b0}};
        end else if (en) begin
          state_nx_s = HIGH;
          cnt_nx_s   = hi_n_s - W'(1);
          start_s    = 1'b1;
          if (apply_s || (nper_a_s == {NW{1'b0}})) begin
            bcnt_nx_s = {NW{1'b0}};
          end else begin
            bcnt_nx_s = bsum_s;
          end
        end else begin
          state_nx_s = IDLE;
          bcnt_nx_s  = {NW{1'b0}};
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {W{1'b0}};
        bcnt_nx_s  = {NW{1'b0}};
      end
    endcase
  end

  // Next values of the registered waveform outputs
  always_comb begin
    sig_nx_s   = (state_nx_s == HIGH);
    medge_nx_s = start_s;
    act_nx_s   = (state_nx_s != IDLE);
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_r   <= 1'b0;
      medge_r <= 1'b0;
      act_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      sig_r   <= sig_nx_s;
      medge_r <= medge_nx_s;
      act_r   <= act_nx_s;
      done_r  <= done_nx_s;
    end
  end

  assign sig   = sig_r;
  assign medge = medge_r;
  assign act   = act_r;
  assign done  = done_r;

endmodule
